// File: rtl/trace_pkg.sv
// Shared types and defaults for the PC trace recorder.
package trace_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_RECORD = 2'd1,
      ST_DUMP   = 2'd2,
      ST_DONE   = 2'd3
   } trace_state_t;

   localparam int PC_W_DEF  = 12;
   localparam int DEPTH_DEF = 64;

endpackage

// File: rtl/trace_ram.sv
// Trace storage: simple dual-port RAM with one write port and one registered read port.
// There is no reset, so the array and its read register map onto block RAM.
module trace_ram
   import trace_pkg::*;
#(
   parameter int DW    = PC_W_DEF,
   parameter int DEPTH = DEPTH_DEF,
   localparam int AW   = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [DW-1:0] wdata,
   input  logic          re,
   input  logic [AW-1:0] raddr,
   output logic [DW-1:0] rdata
);

   logic [DW-1:0] mem [DEPTH];

   // Write when enabled; read with one cycle of latency, holding the output between reads.
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
      if (re) rdata <= mem[raddr];
   end

endmodule

// File: rtl/pc_trace_recorder.sv
// PC trace recorder: captures qualified fetch PCs after arm and plays them back one entry per rd_req.
//
// state  | meaning
// IDLE   | out of reset, nothing recorded
// RECORD | each pc_valid appends pc; stop or a full buffer ends it
// DUMP   | rd_req reads entries out in order
// DONE   | readout finished, contents kept until the next arm
module pc_trace_recorder
   import trace_pkg::*;
#(
   parameter int PC_W  = PC_W_DEF,
   parameter int DEPTH = DEPTH_DEF,
   localparam int AW   = $clog2(DEPTH)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            arm,
   input  logic            stop,
   input  logic            pc_valid,
   input  logic [PC_W-1:0] pc,
   input  logic            rd_req,
   output logic            rd_valid,
   output logic [PC_W-1:0] rd_data,
   output logic [AW-1:0]   rd_idx,
   output logic [AW:0]     count,
   output logic            full,
   output logic            busy
);

   localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
   localparam logic [AW:0] ONE_C   = (AW+1)'(1);
   localparam logic [AW:0] ZERO_C  = '0;

   trace_state_t    state_q;
   logic [AW:0]     count_q;
   logic [AW-1:0]   wr_ptr_q;
   logic [AW:0]     rd_ptr_q;
   logic            rd_valid_q;
   logic [AW-1:0]   rd_idx_q;
   logic [PC_W-1:0] hold_q;
   logic [PC_W-1:0] ram_rdata;

   logic            wr_en;
   logic            rd_issue;
   logic [AW:0]     count_inc;

   assign wr_en     = (state_q == ST_RECORD) && pc_valid;
   assign rd_issue  = (state_q == ST_DUMP) && rd_req && (rd_ptr_q < count_q);
   assign count_inc = count_q + ONE_C;

   trace_ram #(
      .DW    (PC_W),
      .DEPTH (DEPTH)
   ) u_ram (
      .clk   (clk),
      .we    (wr_en),
      .waddr (wr_ptr_q),
      .wdata (pc),
      .re    (rd_issue),
      .raddr (rd_ptr_q[AW-1:0]),
      .rdata (ram_rdata)
   );

   // Sequencing FSM with write/read pointers, entry count and readout registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         count_q    <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         rd_valid_q <= 1'b0;
         rd_idx_q   <= '0;
         hold_q     <= '0;
      end else begin
         rd_valid_q <= rd_issue;
         if (rd_issue)   rd_idx_q <= rd_ptr_q[AW-1:0];
         // Keep the last delivered entry so rd_data stays stable after the RAM output moves on.
         if (rd_valid_q) hold_q   <= ram_rdata;

         case (state_q)
            ST_IDLE, ST_DONE: begin
               if (arm) begin
                  state_q  <= ST_RECORD;
                  count_q  <= '0;
                  wr_ptr_q <= '0;
                  rd_ptr_q <= '0;
               end
            end
            ST_RECORD: begin
               if (pc_valid) begin
                  wr_ptr_q <= wr_ptr_q + AW'(1);
                  count_q  <= count_inc;
               end
               // A pc arriving with stop is still kept; a full buffer ends recording, no wrap.
               if (stop || (pc_valid && (count_inc == DEPTH_C))) state_q <= ST_DUMP;
            end
            ST_DUMP: begin
               if (count_q == ZERO_C) begin
                  state_q <= ST_DONE;
               end else if (rd_issue) begin
                  rd_ptr_q <= rd_ptr_q + ONE_C;
                  if (rd_ptr_q == count_q - ONE_C) state_q <= ST_DONE;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign rd_valid = rd_valid_q;
   assign rd_data  = rd_valid_q ? ram_rdata : hold_q;
   assign rd_idx   = rd_idx_q;
   assign count    = count_q;
   assign full     = (count_q == DEPTH_C);
   assign busy     = (state_q == ST_RECORD);

endmodule

// File: tb/tb_pc_trace_recorder.sv
// Testbench for pc_trace_recorder: directed scenarios plus randomized sessions against a queue model.
module tb_pc_trace_recorder;

   localparam int PC_W  = 12;
   localparam int DEPTH = 64;
   localparam int AW    = $clog2(DEPTH);

   localparam int M_IDLE = 0;
   localparam int M_REC  = 1;
   localparam int M_DUMP = 2;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic            arm = 1'b0;
   logic            stop = 1'b0;
   logic            pc_valid = 1'b0;
   logic [PC_W-1:0] pc = '0;
   logic            rd_req = 1'b0;
   logic            rd_valid;
   logic [PC_W-1:0] rd_data;
   logic [AW-1:0]   rd_idx;
   logic [AW:0]     count;
   logic            full;
   logic            busy;

   pc_trace_recorder #(.PC_W(PC_W), .DEPTH(DEPTH)) dut (
      .clk      (clk),
      .rst      (rst),
      .arm      (arm),
      .stop     (stop),
      .pc_valid (pc_valid),
      .pc       (pc),
      .rd_req   (rd_req),
      .rd_valid (rd_valid),
      .rd_data  (rd_data),
      .rd_idx   (rd_idx),
      .count    (count),
      .full     (full),
      .busy     (busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [PC_W-1:0] data;
      int              idx;
      longint          due;
   } exp_t;

   exp_t            exp_q[$];
   exp_t            e;
   logic [PC_W-1:0] trace[$];
   int              mode = M_IDLE;
   int              rdn = 0;
   longint          cyc_n = 0;
   logic [PC_W-1:0] last_data = '0;
   int              checks = 0;
   int              errors = 0;

   always @(posedge clk) cyc_n++;

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
      end
   endtask

   // Reference behaviour: what one clock edge does given this cycle's inputs.
   task automatic cyc(input bit a, input bit s, input bit v, input logic [PC_W-1:0] p, input bit r);
      arm = a; stop = s; pc_valid = v; pc = p; rd_req = r;
      case (mode)
         M_IDLE: if (a) begin mode = M_REC; trace.delete(); rdn = 0; end
         M_REC: begin
            if (v) trace.push_back(p);
            if (s || trace.size() == DEPTH) mode = M_DUMP;
         end
         default: begin
            if (trace.size() == 0) mode = M_IDLE;
            else if (r) begin
               exp_q.push_back('{trace[rdn], rdn, cyc_n + 1});
               rdn++;
               if (rdn == trace.size()) mode = M_IDLE;
            end
         end
      endcase
      @(posedge clk); #1;
      chk("count", count, trace.size());
      chk("full", full, (trace.size() == DEPTH) ? 1 : 0);
      chk("busy", busy, (mode == M_REC) ? 1 : 0);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      arm = 0; stop = 0; pc_valid = 0; rd_req = 0;
      exp_q.delete();
      trace.delete();
      mode = M_IDLE; rdn = 0; last_data = '0;
      @(posedge clk); #1;
      chk("rst_rd_valid", rd_valid, 0);
      chk("rst_rd_data", rd_data, 0);
      chk("rst_rd_idx", rd_idx, 0);
      chk("rst_count", count, 0);
      chk("rst_full", full, 0);
      chk("rst_busy", busy, 0);
      rst = 1'b0;
   endtask

   task automatic idle_reads(input int n);
      for (int i = 0; i < n; i++) cyc(0, 0, 0, '0, 1);
   endtask

   // Scoreboard monitor: every rd_valid must match the oldest expected read, on time.
   always @(negedge clk) begin
      if (!rst) begin
         if (rd_valid) begin
            if (exp_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL unexpected_rd_valid actual=1 expected=0 idx=%0d t=%0t", rd_idx, $time);
            end else begin
               e = exp_q.pop_front();
               chk("rd_data", rd_data, e.data);
               chk("rd_idx", rd_idx, e.idx);
               chk("rd_latency", cyc_n, e.due);
               last_data = e.data;
            end
         end else begin
            chk("rd_hold", rd_data, last_data);
            if (exp_q.size() > 0 && exp_q[0].due <= cyc_n) begin
               checks++; errors++;
               $display("FAIL missing_rd_valid actual=0 expected=1 idx=%0d t=%0t", exp_q[0].idx, $time);
               void'(exp_q.pop_front());
            end
         end
      end
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int len;
      do_reset();

      // Basic four-entry record and readout.
      cyc(1, 0, 0, '0, 0);
      for (int i = 0; i < 4; i++) cyc(0, 0, 1, PC_W'(4 * i), 0);
      cyc(0, 1, 0, '0, 0);
      for (int i = 0; i < 4; i++) cyc(0, 0, 0, '0, 1);
      idle_reads(3);

      // Overfill: 70 PCs offered, only the first 64 kept.
      cyc(1, 0, 0, '0, 0);
      for (int i = 0; i < 70; i++) cyc(0, 0, 1, PC_W'(4 * i), 0);
      for (int i = 0; i < 64; i++) cyc(0, 0, 0, '0, 1);
      idle_reads(3);

      // stop together with pc_valid still records that PC.
      cyc(1, 0, 0, '0, 0);
      cyc(0, 0, 1, 12'h100, 0);
      cyc(0, 0, 1, 12'h104, 0);
      cyc(0, 1, 1, 12'h010, 0);
      for (int i = 0; i < 3; i++) cyc(0, 0, 0, '0, 1);
      idle_reads(2);

      // Empty recording: DUMP falls through to DONE, which accepts a new arm at once.
      cyc(1, 0, 0, '0, 0);
      cyc(0, 1, 0, '0, 0);
      cyc(0, 0, 0, '0, 1);
      cyc(1, 0, 0, '0, 1);
      cyc(0, 1, 0, '0, 0);
      idle_reads(3);

      // Reset in the middle of a readout.
      cyc(1, 0, 0, '0, 0);
      for (int i = 0; i < 3; i++) cyc(0, 0, 1, PC_W'(12'h200 + 4 * i), 0);
      cyc(0, 1, 0, '0, 0);
      cyc(0, 0, 0, '0, 1);
      do_reset();
      idle_reads(4);

      // Gapped pc_valid.
      cyc(1, 0, 0, '0, 0);
      cyc(0, 0, 1, 12'h020, 0);
      cyc(0, 0, 0, 12'hABC, 0);
      cyc(0, 0, 1, 12'h024, 0);
      cyc(0, 0, 1, 12'h028, 0);
      cyc(0, 1, 0, '0, 0);
      for (int i = 0; i < 3; i++) cyc(0, 0, 0, '0, 1);
      idle_reads(2);

      // Randomized sessions, including stray arm/rd_req/pc_valid and occasional resets.
      for (int it = 0; it < 40; it++) begin
         cyc(1, 0, $urandom_range(0, 1), PC_W'($urandom), $urandom_range(0, 1));
         len = $urandom_range(0, 80);
         for (int i = 0; i < len; i++)
            cyc($urandom_range(0, 9) == 0, 0, $urandom_range(0, 9) < 7, PC_W'($urandom),
                $urandom_range(0, 4) == 0);
         if (mode == M_REC) cyc(0, 1, $urandom_range(0, 1), PC_W'($urandom), 0);
         for (int k = 0; k < 400 && mode != M_IDLE; k++) begin
            if (k == 3 && $urandom_range(0, 9) == 0) begin
               do_reset();
               break;
            end
            cyc($urandom_range(0, 9) == 0, 0, $urandom_range(0, 1), PC_W'($urandom),
                $urandom_range(0, 9) < 7);
         end
         chk("dump_finished", mode, M_IDLE);
         idle_reads(2);
      end

      cyc(0, 0, 0, '0, 0);
      cyc(0, 0, 0, '0, 0);
      chk("drain", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
